// File: rtl/frame_update_scheduler.sv
// Purpose: runs a batch of game-object update engines, one at a time, inside vertical blanking.
// Latency: window opens 2 cycles after the first blanking pixel; each skipped client costs 1 cycle.
// Backpressure: a client holds the window until its done or a timeout; active video aborts the batch.
module frame_update_scheduler #(
   parameter int N_CLIENTS      = 4,
   parameter int V_BLANK_START  = 515,
   parameter int V_ACTIVE_START = 35,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int FRAME_CNT_W    = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [9:0]             H_COUNT,
   input  logic [9:0]             V_COUNT,
   input  logic [N_CLIENTS-1:0]   CLIENT_EN,
   input  logic [N_CLIENTS-1:0]   CLIENT_DONE,
   output logic [N_CLIENTS-1:0]   CLIENT_START,
   output logic [N_CLIENTS-1:0]   CLIENT_GRANT,
   output logic                   BUSY,
   output logic [N_CLIENTS-1:0]   TIMEOUT_FLAGS,
   output logic                   OVERRUN,
   output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

   localparam int IDX_W = $clog2(N_CLIENTS + 1);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [9:0]       V_OPEN   = 10'(V_BLANK_START);
   localparam logic [9:0]       V_CLOSE  = 10'(V_ACTIVE_START);
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_CLIENTS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, DONE} state_t;

   state_t                 state_q, state_n;
   logic [IDX_W-1:0]       idx_q, idx_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic [N_CLIENTS-1:0]   flags_n;
   logic                   ovr_n;
   logic [FRAME_CNT_W-1:0] frame_n;
   logic                   trig_q, trig_prev;
   logic                   trig_pulse, close_win;
   logic [N_CLIENTS-1:0]   sel_vec;
   logic                   en_sel, done_sel;

   function automatic logic [N_CLIENTS-1:0] idx_dec(input logic [IDX_W-1:0] i);
      logic [N_CLIENTS-1:0] v;
      for (int k = 0; k < N_CLIENTS; k++) begin
         v[k] = (i == IDX_W'(k));
      end
      return v;
   endfunction

   // The index runs one past the last client, so per-client bits are picked
   // through the decoder rather than by direct indexing.
   assign sel_vec    = idx_dec(idx_q);
   assign en_sel     = |(CLIENT_EN & sel_vec);
   assign done_sel   = |(CLIENT_DONE & sel_vec);
   assign trig_pulse = trig_q & ~trig_prev;
   assign close_win  = (V_COUNT == V_CLOSE);

   // Next-state logic; the timeout counter counts every granted cycle from START onward.
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      cnt_n   = cnt_q;
      flags_n = TIMEOUT_FLAGS;
      ovr_n   = OVERRUN;
      frame_n = FRAME_CNT;
      case (state_q)
         IDLE: begin
            if (trig_pulse) begin
               state_n = SELECT;
               idx_n   = '0;
            end
         end
         SELECT: begin
            if (idx_q == IDX_END) begin
               state_n = DONE;
            end else if (!en_sel) begin
               idx_n = idx_q + 1'b1;
            end else begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            cnt_n   = cnt_q + 1'b1;
            state_n = WAIT;
         end
         WAIT: begin
            if (done_sel) begin
               idx_n   = idx_q + 1'b1;
               state_n = SELECT;
            end else if (cnt_q == CNT_LAST) begin
               flags_n = TIMEOUT_FLAGS | sel_vec;
               idx_n   = idx_q + 1'b1;
               state_n = SELECT;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DONE: begin
            frame_n = FRAME_CNT + 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Active video returning beats any done, timeout or batch completion.
      if (close_win && state_q != IDLE) begin
         state_n = IDLE;
         ovr_n   = 1'b1;
         flags_n = TIMEOUT_FLAGS;
         frame_n = FRAME_CNT;
      end
   end

   // State, trigger edge detector and outputs, all registered from the next state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         trig_q        <= 1'b0;
         trig_prev     <= 1'b0;
         CLIENT_START  <= '0;
         CLIENT_GRANT  <= '0;
         BUSY          <= 1'b0;
         TIMEOUT_FLAGS <= '0;
         OVERRUN       <= 1'b0;
         FRAME_CNT     <= '0;
      end else begin
         state_q       <= state_n;
         idx_q         <= idx_n;
         cnt_q         <= cnt_n;
         trig_q        <= (V_COUNT == V_OPEN) && (H_COUNT == 10'd0);
         trig_prev     <= trig_q;
         CLIENT_START  <= (state_n == START) ? idx_dec(idx_n) : '0;
         CLIENT_GRANT  <= (state_n == START || state_n == WAIT) ? idx_dec(idx_n) : '0;
         BUSY          <= (state_n != IDLE);
         TIMEOUT_FLAGS <= flags_n;
         OVERRUN       <= ovr_n;
         FRAME_CNT     <= frame_n;
      end
   end

endmodule
